// File: rtl/opb_apb_bridge_mc_if.sv
// OPB request/response and APB master signal bundle for opb_apb_bridge_mc.
// The bridge takes the slave modport; the environment (OPB master + APB slaves) takes master.
interface opb_apb_bridge_mc_if #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic [31:0]             OPB_ADDR;
    logic [DATA_W-1:0]       OPB_DI;
    logic                    OPB_WE;
    logic                    OPB_RE;
    logic [DATA_W-1:0]       OPB_DO;
    logic                    OPB_ACK;
    logic                    OPB_ERR;
    logic                    OPB_BUSY;
    logic                    OPB_OVR;

    logic [NUM_SLV-1:0]        psel;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic                      pwrite;
    logic                      penable;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;

    modport slave (
        input  OPB_ADDR, OPB_DI, OPB_WE, OPB_RE,
        output OPB_DO, OPB_ACK, OPB_ERR, OPB_BUSY, OPB_OVR,
        output psel, paddr, pwdata, pwrite, penable,
        input  prdata, pready, pslverr
    );

    modport master (
        output OPB_ADDR, OPB_DI, OPB_WE, OPB_RE,
        input  OPB_DO, OPB_ACK, OPB_ERR, OPB_BUSY, OPB_OVR,
        input  psel, paddr, pwdata, pwrite, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/opb_apb_bridge_mc.sv
// OPB-to-APB bridge fanning one OPB request out to one of NUM_SLV APB slaves,
// with PREADY wait states, PSLVERR, decode error and ACCESS timeout.
module opb_apb_bridge_mc #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 11,
    parameter int TIMEOUT = 255
) (
    input  logic               OPB_CLK,
    input  logic               OPB_RST,
    opb_apb_bridge_mc_if.slave bus
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic               penable_q, penable_d;
    logic [DATA_W-1:0]  do_q, do_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;

    logic               req;
    logic [SEL_W-1:0]   req_sel;
    logic               dec_ok;
    logic               sel_rdy;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout_hit;
    logic               unused_addr;

    assign req         = bus.OPB_WE | bus.OPB_RE;
    assign req_sel     = bus.OPB_ADDR[SEL_LSB +: SEL_W];
    assign unused_addr = ^bus.OPB_ADDR;
    // Abort on the cycle whose increment would make the counter reach TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) == TIMEOUT);

    // Per-slave response mux; an out-of-range index simply selects nothing.
    always_comb begin
        dec_ok    = 1'b0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_sel == SEL_W'(i)) dec_ok = 1'b1;
            if (idx_q == SEL_W'(i)) begin
                sel_rdy   = bus.pready[i];
                sel_err   = bus.pslverr[i];
                sel_rdata = bus.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        do_d      = do_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        ovr_d     = ovr_q | (req && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    paddr_d  = bus.OPB_ADDR[ADDR_W-1:0];
                    pwdata_d = bus.OPB_DI;
                    pwrite_d = bus.OPB_WE;
                    idx_d    = req_sel;
                    if (dec_ok) begin
                        for (int i = 0; i < NUM_SLV; i++) psel_d[i] = (req_sel == SEL_W'(i));
                        state_d = SETUP;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_rdy || timeout_hit) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    cnt_d     = '0;
                    ack_d     = 1'b1;
                    err_d     = sel_rdy ? sel_err : 1'b1;
                    if (!pwrite_q) do_d = sel_rdy ? sel_rdata : '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECERR: begin
                state_d  = IDLE;
                pwrite_d = 1'b0;
                ack_d    = 1'b1;
                err_d    = 1'b1;
                if (!pwrite_q) do_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            do_q      <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            do_q      <= do_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.psel     = psel_q;
    assign bus.paddr    = paddr_q;
    assign bus.pwdata   = pwdata_q;
    assign bus.pwrite   = pwrite_q;
    assign bus.penable  = penable_q;
    assign bus.OPB_DO   = do_q;
    assign bus.OPB_ACK  = ack_q;
    assign bus.OPB_ERR  = err_q;
    assign bus.OPB_BUSY = (state_q != IDLE);
    assign bus.OPB_OVR  = ovr_q;
endmodule

// File: tb/tb_opb_apb_bridge_mc.sv
// Directed bench for opb_apb_bridge_mc: a 4-slave/TIMEOUT=8 instance and a 3-slave instance
// for the decode-error case.
module tb_opb_apb_bridge_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    opb_apb_bridge_mc_if #(.ADDR_W(11), .DATA_W(32), .NUM_SLV(4)) if0 ();
    opb_apb_bridge_mc_if #(.ADDR_W(11), .DATA_W(32), .NUM_SLV(3)) if1 ();

    opb_apb_bridge_mc #(.ADDR_W(11), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(11), .TIMEOUT(8)) dut0 (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .bus     (if0.slave)
    );

    opb_apb_bridge_mc #(.ADDR_W(11), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(11), .TIMEOUT(255)) dut1 (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .bus     (if1.slave)
    );

    // Issues one request on if0 and waits for OPB_ACK; pready[*] stays low for
    // `waits` ACCESS cycles, then goes high. lat counts negedges from the request edge.
    task automatic run_xfer(input logic we, input logic re, input logic [31:0] addr,
                            input logic [31:0] di, input int waits,
                            output int pen_cnt, output int lat);
        pen_cnt = 0;
        lat     = 0;
        if0.OPB_WE   = we;
        if0.OPB_RE   = re;
        if0.OPB_ADDR = addr;
        if0.OPB_DI   = di;
        @(negedge clk);
        lat = 1;
        if0.OPB_WE = 1'b0;
        if0.OPB_RE = 1'b0;
        while (!if0.OPB_ACK && lat < 40) begin
            if (if0.penable) pen_cnt++;
            if0.pready = (pen_cnt > waits) ? 4'hF : 4'h0;
            @(negedge clk);
            lat++;
        end
        if0.pready = 4'hF;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.psel, if0.paddr, if0.pwdata, if0.pwrite, if0.penable, if0.OPB_DO,
             if0.OPB_ACK, if0.OPB_ERR, if0.OPB_BUSY, if0.OPB_OVR} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: psel=%b paddr=%h pwdata=%h pwrite=%b penable=%b do=%h ack=%b err=%b busy=%b ovr=%b, want all 0",
                     if0.psel, if0.paddr, if0.pwdata, if0.pwrite, if0.penable, if0.OPB_DO,
                     if0.OPB_ACK, if0.OPB_ERR, if0.OPB_BUSY, if0.OPB_OVR);
        end
        checks++;
        if ({if1.psel, if1.penable, if1.OPB_DO, if1.OPB_ACK, if1.OPB_BUSY, if1.OPB_OVR} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: psel=%b penable=%b do=%h ack=%b busy=%b ovr=%b, want all 0",
                     if1.psel, if1.penable, if1.OPB_DO, if1.OPB_ACK, if1.OPB_BUSY, if1.OPB_OVR);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        if0.OPB_WE   = 1'b1;
        if0.OPB_ADDR = 32'h0000_0804;
        if0.OPB_DI   = 32'h1234_5678;
        @(negedge clk);
        if0.OPB_WE = 1'b0;
        checks++;
        if ({if0.psel, if0.paddr, if0.penable, if0.pwrite, if0.OPB_BUSY} !== {4'b0010, 11'h004, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL write_setup: psel=%b paddr=%h penable=%b pwrite=%b busy=%b, want 0010 004 0 1 1",
                     if0.psel, if0.paddr, if0.penable, if0.pwrite, if0.OPB_BUSY);
        end
        checks++;
        if (if0.pwdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_pwdata: got %h want 12345678", if0.pwdata);
        end
        @(negedge clk);
        checks++;
        if ({if0.psel, if0.paddr, if0.penable, if0.pwrite, if0.OPB_ACK} !== {4'b0010, 11'h004, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_access: psel=%b paddr=%h penable=%b pwrite=%b ack=%b, want 0010 004 1 1 0",
                     if0.psel, if0.paddr, if0.penable, if0.pwrite, if0.OPB_ACK);
        end
        @(negedge clk);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.psel, if0.penable, if0.pwrite, if0.OPB_BUSY} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_done: ack=%b err=%b psel=%b penable=%b pwrite=%b busy=%b, want 1 0 0000 0 0 0",
                     if0.OPB_ACK, if0.OPB_ERR, if0.psel, if0.penable, if0.pwrite, if0.OPB_BUSY);
        end
        checks++;
        if ({if0.OPB_DO, if0.paddr, if0.pwdata} !== {32'h0, 11'h004, 32'h1234_5678}) begin
            errors++;
            $display("FAIL write_hold: do=%h paddr=%h pwdata=%h, want 00000000 004 12345678",
                     if0.OPB_DO, if0.paddr, if0.pwdata);
        end
        @(negedge clk);
        checks++;
        if (if0.OPB_ACK !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: ack=%b want 0", if0.OPB_ACK);
        end
    endtask

    task automatic test_wait_read();
        int pen_cnt, lat;
        if0.prdata[2*32 +: 32] = 32'hCAFE_F00D;
        run_xfer(1'b0, 1'b1, 32'h0000_1000, 32'h0, 5, pen_cnt, lat);
        checks++;
        if (pen_cnt !== 6 || lat !== 8) begin
            errors++;
            $display("FAIL wait_timing: penable_cycles=%0d ack_latency=%0d, want 6 8", pen_cnt, lat);
        end
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL wait_read: ack=%b err=%b do=%h, want 1 0 cafef00d", if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_DO} !== {1'b0, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL wait_do_held: ack=%b do=%h, want 0 cafef00d", if0.OPB_ACK, if0.OPB_DO);
        end
    endtask

    task automatic test_slverr();
        int pen_cnt, lat;
        if0.prdata[0 +: 32] = 32'h0BAD_BEEF;
        if0.pslverr = 4'b0001;
        run_xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, pen_cnt, lat);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO} !== {1'b1, 1'b1, 32'h0BAD_BEEF} || lat !== 3) begin
            errors++;
            $display("FAIL slverr: ack=%b err=%b do=%h lat=%0d, want 1 1 0badbeef 3",
                     if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO, lat);
        end
        checks++;
        if (if0.paddr !== 11'h010) begin
            errors++;
            $display("FAIL slverr_paddr_held: paddr=%h want 010", if0.paddr);
        end
        if0.pslverr = 4'b0000;
    endtask

    task automatic test_timeout();
        int pen_cnt, lat;
        if0.prdata[3*32 +: 32] = 32'h1111_2222;
        run_xfer(1'b0, 1'b1, 32'h0000_1800, 32'h0, 100, pen_cnt, lat);
        checks++;
        if (pen_cnt !== 8 || lat !== 10) begin
            errors++;
            $display("FAIL timeout_timing: penable_cycles=%0d ack_latency=%0d, want 8 10", pen_cnt, lat);
        end
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO, if0.psel, if0.penable} !== {1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL timeout_result: ack=%b err=%b do=%h psel=%b penable=%b, want 1 1 ffffffff 0000 0",
                     if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO, if0.psel, if0.penable);
        end
    endtask

    task automatic test_decerr();
        int lat;
        logic sel_seen;
        if1.prdata[1*32 +: 32] = 32'h5555_AAAA;
        @(negedge clk);
        if1.OPB_RE = 1'b1;
        if1.OPB_ADDR = 32'h0000_0800;
        @(negedge clk);
        if1.OPB_RE = 1'b0;
        lat = 1;
        while (!if1.OPB_ACK && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({if1.OPB_ACK, if1.OPB_ERR, if1.OPB_DO} !== {1'b1, 1'b0, 32'h5555_AAAA} || lat !== 3) begin
            errors++;
            $display("FAIL dec_preload: ack=%b err=%b do=%h lat=%0d, want 1 0 5555aaaa 3",
                     if1.OPB_ACK, if1.OPB_ERR, if1.OPB_DO, lat);
        end
        if1.OPB_RE = 1'b1;
        if1.OPB_ADDR = 32'h0000_1800;
        sel_seen = 1'b0;
        @(negedge clk);
        if1.OPB_RE = 1'b0;
        lat = 1;
        checks++;
        if (if1.OPB_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL dec_busy: busy=%b want 1", if1.OPB_BUSY);
        end
        while (!if1.OPB_ACK && lat < 20) begin
            sel_seen = sel_seen | (|if1.psel) | if1.penable;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 2 || sel_seen !== 1'b0) begin
            errors++;
            $display("FAIL dec_timing: ack_latency=%0d psel_seen=%b, want 2 0", lat, sel_seen);
        end
        checks++;
        if ({if1.OPB_ACK, if1.OPB_ERR, if1.OPB_DO, if1.psel} !== {1'b1, 1'b1, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL dec_result: ack=%b err=%b do=%h psel=%b, want 1 1 00000000 000",
                     if1.OPB_ACK, if1.OPB_ERR, if1.OPB_DO, if1.psel);
        end
    endtask

    task automatic test_back_to_back();
        if0.prdata[1*32 +: 32] = 32'h1357_9BDF;
        @(negedge clk);
        if0.OPB_WE = 1'b1;
        if0.OPB_ADDR = 32'h0000_0020;
        if0.OPB_DI = 32'h1111_1111;
        @(negedge clk);
        if0.OPB_WE = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if0.OPB_ACK !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ack: ack=%b want 1", if0.OPB_ACK);
        end
        if0.OPB_RE = 1'b1;
        if0.OPB_ADDR = 32'h0000_0844;
        @(negedge clk);
        if0.OPB_RE = 1'b0;
        checks++;
        if ({if0.psel, if0.paddr, if0.pwrite, if0.penable, if0.OPB_BUSY} !== {4'b0010, 11'h044, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_accept: psel=%b paddr=%h pwrite=%b penable=%b busy=%b, want 0010 044 0 0 1",
                     if0.psel, if0.paddr, if0.pwrite, if0.penable, if0.OPB_BUSY);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO, if0.OPB_OVR} !== {1'b1, 1'b0, 32'h1357_9BDF, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: ack=%b err=%b do=%h ovr=%b, want 1 0 13579bdf 0",
                     if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO, if0.OPB_OVR);
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        if0.OPB_WE = 1'b1;
        if0.OPB_ADDR = 32'h0000_0800;
        if0.OPB_DI = 32'hA5A5_A5A5;
        @(negedge clk);
        if0.OPB_WE = 1'b0;
        if0.OPB_RE = 1'b1;
        if0.OPB_ADDR = 32'h0000_1000;
        @(negedge clk);
        if0.OPB_RE = 1'b0;
        checks++;
        if ({if0.OPB_OVR, if0.psel, if0.paddr, if0.pwrite, if0.penable, if0.pwdata} !==
            {1'b1, 4'b0010, 11'h000, 1'b1, 1'b1, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL ovr_access: ovr=%b psel=%b paddr=%h pwrite=%b penable=%b pwdata=%h, want 1 0010 000 1 1 a5a5a5a5",
                     if0.OPB_OVR, if0.psel, if0.paddr, if0.pwrite, if0.penable, if0.pwdata);
        end
        @(negedge clk);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO} !== {1'b1, 1'b0, 32'h1357_9BDF}) begin
            errors++;
            $display("FAIL ovr_first_done: ack=%b err=%b do=%h, want 1 0 13579bdf", if0.OPB_ACK, if0.OPB_ERR, if0.OPB_DO);
        end
        @(negedge clk);
        checks++;
        if ({if0.OPB_ACK, if0.OPB_BUSY, if0.OPB_OVR, if0.psel} !== {1'b0, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL ovr_dropped: ack=%b busy=%b ovr=%b psel=%b, want 0 0 1 0000",
                     if0.OPB_ACK, if0.OPB_BUSY, if0.OPB_OVR, if0.psel);
        end
    endtask

    task automatic test_reset_in_access();
        logic ack_seen;
        @(negedge clk);
        if0.OPB_RE = 1'b1;
        if0.OPB_ADDR = 32'h0000_1000;
        if0.pready = 4'h0;
        @(negedge clk);
        if0.OPB_RE = 1'b0;
        @(negedge clk);
        checks++;
        if (if0.penable !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_access: penable=%b want 1", if0.penable);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({if0.psel, if0.penable, if0.OPB_ACK, if0.OPB_BUSY, if0.OPB_OVR, if0.OPB_DO} !== '0) begin
            errors++;
            $display("FAIL rst_in_access: psel=%b penable=%b ack=%b busy=%b ovr=%b do=%h, want all 0",
                     if0.psel, if0.penable, if0.OPB_ACK, if0.OPB_BUSY, if0.OPB_OVR, if0.OPB_DO);
        end
        rst = 1'b0;
        if0.pready = 4'hF;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen = ack_seen | if0.OPB_ACK;
        end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ack: ack_seen=%b want 0", ack_seen);
        end
    endtask

    initial begin
        if0.OPB_ADDR = '0; if0.OPB_DI = '0; if0.OPB_WE = 1'b0; if0.OPB_RE = 1'b0;
        if0.prdata = '0;   if0.pready = 4'hF; if0.pslverr = '0;
        if1.OPB_ADDR = '0; if1.OPB_DI = '0; if1.OPB_WE = 1'b0; if1.OPB_RE = 1'b0;
        if1.prdata = '0;   if1.pready = 3'h7; if1.pslverr = '0;

        test_reset();
        test_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_decerr();
        test_back_to_back();
        test_overrun();
        test_reset_in_access();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
